// File: rtl/calc1.sv
// ----------------------------------------------------------------------------
// calc1 -- four independent two-operand calculator ports.
//
// Each port accepts a command and a first operand in one cycle and a second
// operand in the next cycle. The result appears on its outputs for exactly one
// cycle, one cycle after the second operand is taken. Ports do not share any
// state and are not arbitrated against each other.
//
// Ports (top level, in positional order):
//   out_data1..4  [0:31] out : registered result, 0 whenever out_respN is 0
//   out_resp1..4  [0:1]  out : 0 none, 1 success, 2 overflow/underflow/invalid
//   c_clk                in  : rising-edge clock
//   reqN_cmd_in   [0:3]  in  : command (0 nop, 1 add, 2 sub, 5 shl, 6 shr)
//   reqN_data_in  [0:31] in  : operand, first or second depending on port state
//   reset         [1:7]  in  : reset[1] is the async active-low reset; the
//                              remaining bits carry no function
//
// The bus ranges are MSB-first ([0:N]); inside the port datapath everything is
// handled as conventional [N-1:0] vectors, which keeps the MSB in place.
// ----------------------------------------------------------------------------

// ----------------------------------------------------------------------------
// calc1_port -- one calculator channel: IDLE -> OP2 -> RESP -> IDLE.
//   clk       in  : clock
//   rst_n     in  : asynchronous active-low reset
//   cmd       in  : command nibble
//   data      in  : operand bus
//   res_data  out : registered result data
//   res_resp  out : registered response code
// ----------------------------------------------------------------------------
module calc1_port #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [3:0]        cmd,
    input  logic [DATA_W-1:0] data,
    output logic [DATA_W-1:0] res_data,
    output logic [1:0]        res_resp
);

    localparam int SH_W = $clog2(DATA_W);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_OP2  = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    localparam logic [3:0] CMD_NOP = 4'd0;
    localparam logic [3:0] CMD_ADD = 4'd1;
    localparam logic [3:0] CMD_SUB = 4'd2;
    localparam logic [3:0] CMD_SHL = 4'd5;
    localparam logic [3:0] CMD_SHR = 4'd6;

    localparam logic [1:0] RESP_NONE = 2'd0;
    localparam logic [1:0] RESP_OK   = 2'd1;
    localparam logic [1:0] RESP_ERR  = 2'd2;

    logic [1:0]        state;
    logic [3:0]        op_cmd;
    logic [DATA_W-1:0] op1;
    logic [DATA_W-1:0] op2;

    logic [DATA_W:0]   sum;
    logic [SH_W-1:0]   shamt;
    logic [DATA_W-1:0] result_data;
    logic [1:0]        result_resp;

    // Control: the FSM is the only thing that decides whether an operation is
    // live, so resetting it is enough to discard anything in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: if (cmd != CMD_NOP) state <= ST_OP2;
                ST_OP2:  state <= ST_RESP;
                ST_RESP: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Operand capture. Any nonzero command starts an operation, including the
    // invalid ones, so they still consume the second-operand cycle. Commands
    // seen outside IDLE are simply not looked at.
    always_ff @(posedge clk) begin
        if (state == ST_IDLE && cmd != CMD_NOP) begin
            op_cmd <= cmd;
            op1    <= data;
        end
        if (state == ST_OP2) begin
            op2 <= data;
        end
    end

    // Result computation from the captured operands.
    always_comb begin
        sum         = {1'b0, op1} + {1'b0, op2};
        shamt       = op2[SH_W-1:0];
        result_data = '0;
        result_resp = RESP_ERR;
        case (op_cmd)
            CMD_ADD: begin
                // A carry out of the top bit is reported as overflow.
                if (!sum[DATA_W]) begin
                    result_data = sum[DATA_W-1:0];
                    result_resp = RESP_OK;
                end
            end
            CMD_SUB: begin
                // Unsigned: a negative difference is reported as underflow.
                if (op2 <= op1) begin
                    result_data = op1 - op2;
                    result_resp = RESP_OK;
                end
            end
            CMD_SHL: begin
                result_data = op1 << shamt;
                result_resp = RESP_OK;
            end
            CMD_SHR: begin
                result_data = op1 >> shamt;
                result_resp = RESP_OK;
            end
            default: begin
                result_data = '0;
                result_resp = RESP_ERR;
            end
        endcase
    end

    // Output register: the result is presented for the single cycle that
    // follows the RESP state; every other cycle drives none/zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_data <= '0;
            res_resp <= RESP_NONE;
        end else if (state == ST_RESP) begin
            res_data <= result_data;
            res_resp <= result_resp;
        end else begin
            res_data <= '0;
            res_resp <= RESP_NONE;
        end
    end

endmodule

// ----------------------------------------------------------------------------
// calc1 -- top level: four calc1_port instances sharing clock and reset.
// ----------------------------------------------------------------------------
module calc1 (
    output logic [0:31] out_data1,
    output logic [0:31] out_data2,
    output logic [0:31] out_data3,
    output logic [0:31] out_data4,
    output logic [0:1]  out_resp1,
    output logic [0:1]  out_resp2,
    output logic [0:1]  out_resp3,
    output logic [0:1]  out_resp4,
    input  logic        c_clk,
    input  logic [0:3]  req1_cmd_in,
    input  logic [0:31] req1_data_in,
    input  logic [0:3]  req2_cmd_in,
    input  logic [0:31] req2_data_in,
    input  logic [0:3]  req3_cmd_in,
    input  logic [0:31] req3_data_in,
    input  logic [0:3]  req4_cmd_in,
    input  logic [0:31] req4_data_in,
    input  logic [1:7]  reset
);

    logic rst_n;
    logic unused_reset_bits;

    assign rst_n = reset[1];
    // reset[2:7] have no function; they are tied off here on purpose.
    assign unused_reset_bits = &{1'b0, reset[2:7]};

    calc1_port #(.DATA_W(32)) u_port1 (
        .clk      (c_clk),
        .rst_n    (rst_n),
        .cmd      (req1_cmd_in),
        .data     (req1_data_in),
        .res_data (out_data1),
        .res_resp (out_resp1)
    );

    calc1_port #(.DATA_W(32)) u_port2 (
        .clk      (c_clk),
        .rst_n    (rst_n),
        .cmd      (req2_cmd_in),
        .data     (req2_data_in),
        .res_data (out_data2),
        .res_resp (out_resp2)
    );

    calc1_port #(.DATA_W(32)) u_port3 (
        .clk      (c_clk),
        .rst_n    (rst_n),
        .cmd      (req3_cmd_in),
        .data     (req3_data_in),
        .res_data (out_data3),
        .res_resp (out_resp3)
    );

    calc1_port #(.DATA_W(32)) u_port4 (
        .clk      (c_clk),
        .rst_n    (rst_n),
        .cmd      (req4_cmd_in),
        .data     (req4_data_in),
        .res_data (out_data4),
        .res_resp (out_resp4)
    );

endmodule

// File: tb/tb_calc1.sv
// ----------------------------------------------------------------------------
// tb_calc1 -- self-checking bench for calc1.
// A transaction-level model tracks, per port, when an operation starts, which
// cycle its response is due and when the port may accept again; a compare
// process checks all four ports on every falling edge. Directed transactions
// additionally check hand-computed literal results.
// ----------------------------------------------------------------------------
module tb_calc1;

    logic        c_clk = 1'b0;
    logic [1:7]  reset;
    logic [0:3]  cmd  [4];
    logic [0:31] din  [4];
    logic [0:31] dout [4];
    logic [0:1]  rsp  [4];

    always #5 c_clk = ~c_clk;

    calc1 dut (
        .out_data1    (dout[0]),
        .out_data2    (dout[1]),
        .out_data3    (dout[2]),
        .out_data4    (dout[3]),
        .out_resp1    (rsp[0]),
        .out_resp2    (rsp[1]),
        .out_resp3    (rsp[2]),
        .out_resp4    (rsp[3]),
        .c_clk        (c_clk),
        .req1_cmd_in  (cmd[0]),
        .req1_data_in (din[0]),
        .req2_cmd_in  (cmd[1]),
        .req2_data_in (din[1]),
        .req3_cmd_in  (cmd[2]),
        .req3_data_in (din[2]),
        .req4_cmd_in  (cmd[3]),
        .req4_data_in (din[3]),
        .reset        (reset)
    );

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // Model state per port.
    int          pend [4];
    int          t1   [4];
    int          rc   [4];
    int          fr   [4];
    int          mcmd [4];
    logic [31:0] mop1 [4];
    logic [1:0]  er   [4];
    logic [31:0] ed   [4];

    // Vectors for the four-port simultaneous transactions.
    logic [3:0]  v_cmd [4];
    logic [31:0] v_a   [4];
    logic [31:0] v_b   [4];
    logic [1:0]  v_r   [4];
    logic [31:0] v_d   [4];

    // Expected response of one operation, computed with wide arithmetic.
    function automatic void spec_result(input int c, input logic [31:0] a, input logic [31:0] b,
                                        output logic [1:0] r, output logic [31:0] d);
        longint unsigned wa, wb, s;
        int sh;
        wa = 64'(a);
        wb = 64'(b);
        sh = int'(wb % 64'd32);
        r  = 2'd2;
        d  = 32'd0;
        case (c)
            1: begin
                s = wa + wb;
                if (s <= 64'hFFFF_FFFF) begin r = 2'd1; d = s[31:0]; end
            end
            2: begin
                if (wb <= wa) begin s = wa - wb; r = 2'd1; d = s[31:0]; end
            end
            5: begin s = (wa << sh) & 64'hFFFF_FFFF; r = 2'd1; d = s[31:0]; end
            6: begin s = wa >> sh; r = 2'd1; d = s[31:0]; end
            default: begin r = 2'd2; d = 32'd0; end
        endcase
    endfunction

    task automatic model_clear();
        for (int p = 0; p < 4; p++) begin
            pend[p] = 0;
            t1[p]   = 0;
            rc[p]   = -1;
            fr[p]   = 0;
        end
    endtask

    // Model: op1 at edge t, op2 at edge t+1, response visible after edge t+2,
    // port free again from edge t+3.
    always begin
        @(posedge c_clk);
        cyc++;
        if (reset[1] === 1'b1) begin
            for (int p = 0; p < 4; p++) begin
                if (pend[p] != 0) begin
                    if (cyc == t1[p] + 1) begin
                        spec_result(mcmd[p], mop1[p], din[p], er[p], ed[p]);
                        rc[p]   = cyc + 1;
                        fr[p]   = cyc + 2;
                        pend[p] = 0;
                    end
                end else if (cyc >= fr[p] && cmd[p] != 4'd0) begin
                    pend[p] = 1;
                    t1[p]   = cyc;
                    mcmd[p] = int'(cmd[p]);
                    mop1[p] = din[p];
                end
            end
        end
    end

    // Compare process: every falling edge, every port.
    always begin
        @(negedge c_clk);
        for (int p = 0; p < 4; p++) begin
            logic [1:0]  xr;
            logic [31:0] xd;
            xr = (cyc == rc[p]) ? er[p] : 2'd0;
            xd = (cyc == rc[p]) ? ed[p] : 32'd0;
            checks++;
            if (rsp[p] !== xr || dout[p] !== xd) begin
                failures++;
                $display("FAIL cmp_port%0d cyc=%0d got resp=%0d data=%h want resp=%0d data=%h",
                         p + 1, cyc, rsp[p], dout[p], xr, xd);
            end
        end
    end

    task automatic chk(input string nm, input logic [1:0] ar, input logic [1:0] xr,
                       input logic [31:0] ad, input logic [31:0] xd);
        checks++;
        if (ar !== xr || ad !== xd) begin
            failures++;
            $display("FAIL %s got resp=%0d data=%h want resp=%0d data=%h", nm, ar, ad, xr, xd);
        end
    endtask

    // Port 1 transaction; called just after a falling edge, returns just after
    // the falling edge on which the response is visible.
    task automatic tx1(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                       input logic [1:0] xr, input logic [31:0] xd, input string nm);
        cmd[0] = c;
        din[0] = a;
        @(negedge c_clk); #1;
        cmd[0] = 4'd1;              // ignored: port is in its second-operand cycle
        din[0] = b;
        @(negedge c_clk); #1;
        chk({nm, "_early"}, rsp[0], 2'd0, dout[0], 32'd0);
        cmd[0] = 4'd2;              // ignored: port is about to respond
        din[0] = 32'hDEAD_BEEF;
        @(negedge c_clk); #1;
        cmd[0] = 4'd0;
        din[0] = 32'd0;
        chk(nm, rsp[0], xr, dout[0], xd);
    endtask

    task automatic tx4(input string nm);
        for (int p = 0; p < 4; p++) begin cmd[p] = v_cmd[p]; din[p] = v_a[p]; end
        @(negedge c_clk); #1;
        for (int p = 0; p < 4; p++) begin cmd[p] = 4'd0; din[p] = v_b[p]; end
        @(negedge c_clk); #1;
        for (int p = 0; p < 4; p++) din[p] = 32'd0;
        @(negedge c_clk); #1;
        for (int p = 0; p < 4; p++) chk($sformatf("%s_p%0d", nm, p + 1), rsp[p], v_r[p], dout[p], v_d[p]);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 7'b0;
        for (int p = 0; p < 4; p++) begin cmd[p] = 4'd0; din[p] = 32'd0; end
        model_clear();
        repeat (3) @(negedge c_clk);
        #1;
        for (int p = 0; p < 4; p++) chk($sformatf("reset_p%0d", p + 1), rsp[p], 2'd0, dout[p], 32'd0);

        reset = 7'b1010110;         // only reset[1] matters

        tx1(4'd1, 32'h0000_0001, 32'h1FFF_FFFF, 2'd1, 32'h2000_0000, "add_1_1fff");
        tx1(4'd1, 32'h1FFF_FFFF, 32'h1FFF_FFFF, 2'd1, 32'h3FFF_FFFE, "add_1fff_1fff");
        tx1(4'd1, 32'h0,         32'h0,         2'd1, 32'h0,         "add_0_0");
        tx1(4'd1, 32'hFFFF_FFFF, 32'h1,         2'd2, 32'h0,         "add_carry");
        tx1(4'd2, 32'h1,         32'hF,         2'd2, 32'h0,         "sub_under");
        tx1(4'd2, 32'hF,         32'h1,         2'd1, 32'hE,         "sub_f_1");
        tx1(4'd2, 32'h1234_5678, 32'h1234_5678, 2'd1, 32'h0,         "sub_equal");
        tx1(4'd3, 32'h1,         32'h1,         2'd2, 32'h0,         "cmd3");
        tx1(4'd4, 32'h1,         32'h1,         2'd2, 32'h0,         "cmd4");
        tx1(4'd15, 32'h5,        32'h5,         2'd2, 32'h0,         "cmd15");
        for (int k = 0; k < 32; k++)
            tx1(4'd1, 32'h1 << k, 32'h0, 2'd1, 32'h1 << k, $sformatf("add_pow2_%0d", k));
        tx1(4'd5, 32'h1,         32'd31,        2'd1, 32'h8000_0000, "shl_31");
        tx1(4'd6, 32'h8000_0000, 32'd31,        2'd1, 32'h1,         "shr_31");
        tx1(4'd5, 32'h0000_00F0, 32'hFFFF_FFE4, 2'd1, 32'h0000_0F00, "shl_low5");
        tx1(4'd6, 32'hABCD_1234, 32'd0,         2'd1, 32'hABCD_1234, "shr_0");

        v_cmd = '{4'd1, 4'd2, 4'd5, 4'd6};
        v_a   = '{32'd10, 32'd100, 32'd3, 32'hF000_0000};
        v_b   = '{32'd20, 32'd1, 32'd4, 32'd28};
        v_r   = '{2'd1, 2'd1, 2'd1, 2'd1};
        v_d   = '{32'd30, 32'd99, 32'h30, 32'hF};
        tx4("multi_ok");

        v_cmd = '{4'd2, 4'd1, 4'd9, 4'd1};
        v_a   = '{32'd1, 32'hFFFF_FFFF, 32'd7, 32'd7};
        v_b   = '{32'd2, 32'hFFFF_FFFF, 32'd7, 32'd8};
        v_r   = '{2'd2, 2'd2, 2'd2, 2'd1};
        v_d   = '{32'd0, 32'd0, 32'd0, 32'd15};
        tx4("multi_err");

        // Reset while port 1 waits for its second operand.
        cmd[0] = 4'd1; din[0] = 32'd5;
        @(negedge c_clk); #1;
        cmd[0] = 4'd0; din[0] = 32'd6;
        #2;
        reset[1] = 1'b0;
        model_clear();
        #1;
        chk("rst_op2", rsp[0], 2'd0, dout[0], 32'd0);
        @(negedge c_clk); #1;
        reset[1] = 1'b1;
        repeat (3) @(negedge c_clk);
        #1;
        tx1(4'd1, 32'd40, 32'd2, 2'd1, 32'd42, "after_rst_op2");

        // Reset while the response is on the outputs: must drop at once.
        cmd[0] = 4'd2; din[0] = 32'd9;
        @(negedge c_clk); #1;
        cmd[0] = 4'd0; din[0] = 32'd4;
        @(negedge c_clk); #1;
        din[0] = 32'd0;
        @(negedge c_clk); #1;
        chk("resp_before_rst", rsp[0], 2'd1, dout[0], 32'd5);
        #2;
        reset[1] = 1'b0;
        model_clear();
        #1;
        chk("rst_resp_async", rsp[0], 2'd0, dout[0], 32'd0);
        @(negedge c_clk); #1;
        reset[1] = 1'b1;
        tx1(4'd6, 32'h0000_0100, 32'd8, 2'd1, 32'h1, "after_rst_resp");

        repeat (3) @(negedge c_clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
